// File: rtl/sync_deser_pkg.sv
// Shared types and default geometry for the sync-hunting serial deserializer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sync_deser_pkg;

  typedef enum logic [0:0] {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int             DEF_WIDTH        = 8;
  localparam int             DEF_SYNC_W       = 4;
  localparam logic [3:0]     DEF_SYNC_PATTERN = 4'b1011;
  localparam int             DEF_FRAME_WORDS  = 2;

endpackage

// File: rtl/sync_deserializer_if.sv
// Serial input plus valid/ready word output bundle of the deserializer.
// Latency: n/a (wiring only).
// Backpressure: word_ready qualifies word_valid; perr exists only with PARITY_CHECK_EN.
interface sync_deserializer_if #(
  parameter int WIDTH = 8
);
  logic             d_in;
  logic             d_en;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic             locked;
  logic             overrun;
`ifdef PARITY_CHECK_EN
  logic             perr;
`endif

  // deserializer side
  modport master (
    input  d_in, d_en, word_ready,
`ifdef PARITY_CHECK_EN
    output perr,
`endif
    output word_out, word_valid, locked, overrun
  );

  // stimulus / downstream side
  modport slave (
    output d_in, d_en, word_ready,
`ifdef PARITY_CHECK_EN
    input  perr,
`endif
    input  word_out, word_valid, locked, overrun
  );
endinterface

// File: rtl/deser_shift_reg.sv
// Shift register: strobed bits enter the LSB, synchronous clear wins over shift, parallel read.
// Latency: 1 cycle from strobe to q.
// Backpressure: none; shifts on every edge with en=1.
module deser_shift_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         d,
  output logic [W-1:0] q
);

  // clear has priority so a frame boundary can wipe the window on a strobed edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= {q[W-2:0], d};
  end

endmodule

// File: rtl/sync_deserializer.sv
// Hunts for SYNC_PATTERN in a strobed serial stream, then assembles FRAME_WORDS words of WIDTH bits.
// Latency: word/valid 1 cycle after its final bit; locked 1 cycle after the last sync bit.
// Backpressure: one held word; a word completing while the held one is unaccepted is dropped (overrun pulse).
// Optional: PARITY_CHECK_EN adds one even-parity bit per word and the perr pulse.
module sync_deserializer
  import sync_deser_pkg::*;
#(
  parameter int               WIDTH        = DEF_WIDTH,
  parameter int               SYNC_W       = DEF_SYNC_W,
  parameter logic [SYNC_W-1:0] SYNC_PATTERN = DEF_SYNC_PATTERN,
  parameter int               FRAME_WORDS  = DEF_FRAME_WORDS
) (
  input logic              clk,
  input logic              rst_n,
  sync_deserializer_if.master bus
);

  localparam logic [0:0] ST_HUNT = HUNT;
  localparam logic [0:0] ST_LOCK = LOCK;
`ifdef PARITY_CHECK_EN
  localparam int LAST_BIT = WIDTH;
`else
  localparam int LAST_BIT = WIDTH - 1;
`endif
  localparam int BCW = $clog2(WIDTH + 2);
  localparam int WCW = $clog2(FRAME_WORDS + 1);

  logic [0:0]        state;
  logic [BCW-1:0]    bit_cnt;
  logic [WCW-1:0]    word_cnt;
  logic [SYNC_W-1:0] win_q;
  logic [WIDTH-1:0]  asm_q;
  logic [WIDTH-1:0]  word_asm;
  logic              hunting, sync_hit, data_bit, word_done, frame_done, load, accept;
  logic              unused_msb;

  assign hunting    = (state == ST_HUNT);
  // the window compare includes the bit arriving on this edge
  assign sync_hit   = hunting && bus.d_en && ({win_q[SYNC_W-2:0], bus.d_in} == SYNC_PATTERN);
  assign data_bit   = !hunting && bus.d_en && (bit_cnt < BCW'(WIDTH));
  assign word_done  = !hunting && bus.d_en && (bit_cnt == BCW'(LAST_BIT));
  assign frame_done = word_done && (word_cnt == WCW'(FRAME_WORDS - 1));
  assign accept     = bus.word_valid && bus.word_ready;
  assign load       = word_done && (!bus.word_valid || bus.word_ready);
  assign bus.locked = (state == ST_LOCK);

`ifdef PARITY_CHECK_EN
  logic parity_bad;
  // the final strobe is the parity bit, so the data is already fully in the register
  assign word_asm   = asm_q;
  assign parity_bad = ^{asm_q, bus.d_in};
  assign unused_msb = win_q[SYNC_W-1];
`else
  // the final data bit is folded in combinationally so the word loads on its own edge
  assign word_asm   = {asm_q[WIDTH-2:0], bus.d_in};
  assign unused_msb = win_q[SYNC_W-1] ^ asm_q[WIDTH-1];
`endif

  deser_shift_reg #(.W(SYNC_W)) u_sync_win (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (hunting && bus.d_en),
    .clr   (frame_done),
    .d     (bus.d_in),
    .q     (win_q)
  );

  deser_shift_reg #(.W(WIDTH)) u_word_asm (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (data_bit),
    .clr   (sync_hit),
    .d     (bus.d_in),
    .q     (asm_q)
  );

  // hunt/lock sequencing with bit and word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_HUNT;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (sync_hit) begin
      state    <= ST_LOCK;
      bit_cnt  <= '0;
      word_cnt <= '0;
    end else if (word_done) begin
      bit_cnt <= '0;
      if (frame_done) begin
        state    <= ST_HUNT;
        word_cnt <= '0;
      end else begin
        word_cnt <= word_cnt + WCW'(1);
      end
    end else if (!hunting && bus.d_en) begin
      bit_cnt <= bit_cnt + BCW'(1);
    end
  end

  // single-entry output holding register with drop-on-full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.word_out   <= '0;
      bus.word_valid <= 1'b0;
      bus.overrun    <= 1'b0;
    end else begin
      bus.overrun <= word_done && !load;
      if (load) begin
        bus.word_out   <= word_asm;
        bus.word_valid <= 1'b1;
      end else if (accept) begin
        bus.word_valid <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  // one-cycle parity error pulse; the word itself is still delivered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.perr <= 1'b0;
    else        bus.perr <= word_done && parity_bad;
  end
`endif

endmodule

// File: tb/tb_sync_deserializer.sv
// Randomised plus directed bench for sync_deserializer with a frame-level reference model and scoreboard.
// Build with PARITY_CHECK_EN defined to exercise the parity variant.
module tb_sync_deserializer;
  import sync_deser_pkg::*;

  localparam int             WIDTH       = DEF_WIDTH;
  localparam int             SYNC_W      = DEF_SYNC_W;
  localparam logic [3:0]     SYNC_PAT    = DEF_SYNC_PATTERN;
  localparam int             FRAME_WORDS = DEF_FRAME_WORDS;
`ifdef PARITY_CHECK_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif

  typedef struct {
    bit locked;
    bit valid;
    bit ovr;
    bit pe;
  } status_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sync_deserializer_if #(.WIDTH(WIDTH)) bus ();

  sync_deserializer #(
    .WIDTH(WIDTH), .SYNC_W(SYNC_W), .SYNC_PATTERN(SYNC_PAT), .FRAME_WORDS(FRAME_WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  status_t          st_q[$];
  logic [WIDTH-1:0] word_q[$];

  // reference model state: frame-level view of the stream
  bit          m_hunt;
  int          m_win;
  int          m_nbits;
  int          m_nwords;
  int unsigned m_acc;
  bit          m_held;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hunt = 1'b1; m_win = 0; m_nbits = 0; m_nwords = 0; m_acc = 0; m_held = 1'b0;
    st_q.delete();
    word_q.delete();
  endfunction

  // effect of one clock edge given the inputs present at that edge
  function automatic void model_step(input bit b, input bit en, input bit rdy);
    status_t s;
    bit loaded;
    loaded = 1'b0;
    s.ovr  = 1'b0;
    s.pe   = 1'b0;
    if (en) begin
      if (m_hunt) begin
        m_win = ((m_win * 2) + int'(b)) % (1 << SYNC_W);
        if (m_win == int'(SYNC_PAT)) begin
          m_hunt = 1'b0; m_nbits = 0; m_nwords = 0; m_acc = 0;
        end
      end else begin
        if (m_nbits < WIDTH) m_acc = m_acc * 2 + int'(b);
        else                 s.pe = ((($countones(m_acc) + int'(b)) % 2) == 1);
        m_nbits++;
        if (m_nbits == WIDTH + PB) begin
          m_nbits = 0;
          m_nwords++;
          if (!m_held || rdy) begin
            word_q.push_back(m_acc[WIDTH-1:0]);
            loaded = 1'b1;
          end else begin
            s.ovr = 1'b1;
          end
          m_acc = 0;
          if (m_nwords == FRAME_WORDS) begin
            m_hunt = 1'b1;
            m_win  = 0;
          end
        end
      end
    end
    if (loaded)            m_held = 1'b1;
    else if (m_held && rdy) m_held = 1'b0;
    s.locked = !m_hunt;
    s.valid  = m_held;
    st_q.push_back(s);
  endfunction

  task automatic cyc(input bit b, input bit en, input bit rdy);
    bus.d_in       = b;
    bus.d_en       = en;
    bus.word_ready = rdy;
    @(posedge clk);
    model_step(b, en, rdy);
    #2;
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) cyc(1'b0, 1'b0, rdy);
  endtask

  task automatic send_sync(input bit rdy);
    logic [3:0] p;
    p = SYNC_PAT;
    for (int i = SYNC_W - 1; i >= 0; i--) cyc(p[i], 1'b1, rdy);
  endtask

  // rdy_last is the ready value on the edge that completes the word
  task automatic send_word(input int unsigned v, input bit rdy, input bit rdy_last,
                           input bit flip, input bit gap);
    bit r;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      r = (i == 0 && PB == 0) ? rdy_last : rdy;
      cyc(v[i], 1'b1, r);
      if (gap) cyc(1'($urandom_range(0, 1)), 1'b0, r);
    end
    if (PB == 1) cyc((^v[WIDTH-1:0]) ^ flip, 1'b1, rdy_last);
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    repeat (n) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  // monitor: compares DUT outputs against the scoreboard away from the active edge
  initial begin
    status_t s;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        chk("rst_word_valid", bus.word_valid, 0);
        chk("rst_locked", bus.locked, 0);
        chk("rst_overrun", bus.overrun, 0);
        chk("rst_word_out", bus.word_out, 0);
`ifdef PARITY_CHECK_EN
        chk("rst_perr", bus.perr, 0);
`endif
      end else if (st_q.size() > 0) begin
        s = st_q.pop_front();
        chk("locked", bus.locked, s.locked);
        chk("word_valid", bus.word_valid, s.valid);
        chk("overrun", bus.overrun, s.ovr);
`ifdef PARITY_CHECK_EN
        chk("perr", bus.perr, s.pe);
`endif
        if (bus.word_valid === 1'b1) begin
          if (word_q.size() == 0) begin
            chk("word_unexpected", 1, 0);
          end else begin
            chk("word_out", bus.word_out, word_q[0]);
            if (bus.word_ready === 1'b1) void'(word_q.pop_front());
          end
        end
      end
    end
  end

  // stimulus
  initial begin
    bus.d_in = 1'b0; bus.d_en = 1'b0; bus.word_ready = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1;
    do_reset(2);

    // partial frame, then reset in the middle of it
    cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
    send_sync(1'b1);
    cyc(1'b1, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1); cyc(1'b1, 1'b1, 1'b1);
    do_reset(3);

    // 0,0 then 1011, then two words accepted immediately
    cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b1);
    send_sync(1'b1);
    send_word(32'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    send_word(32'hF0, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // no ready for the whole frame: second word overruns, first stays held
    send_sync(1'b0);
    send_word(32'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'hF0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3, 1'b0);
    idle(2, 1'b1);

    // ready arrives exactly on the completing edge of the second word
    send_sync(1'b0);
    send_word(32'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    send_word(32'hF0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // strobe every other cycle, data containing the sync pattern
    send_sync(1'b1);
    send_word(32'hBB, 1'b1, 1'b1, 1'b0, 1'b1);
    send_word(32'h0B, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(3, 1'b1);

    // wrong then correct parity bit (no effect without the parity build)
    send_sync(1'b1);
    send_word(32'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    send_word(32'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b1);

    // randomised stream with occasional explicit syncs and one mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1700) do_reset(2);
      if ($urandom_range(0, 40) == 0) send_sync(1'($urandom_range(0, 1)));
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
    end

    // drain anything still held and confirm the scoreboard emptied
    idle(WIDTH + 10, 1'b1);
    @(negedge clk);
    #1;
    chk("drain_word_q_empty", word_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
